// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle FSM and the datapath.
// master is the controller side; slave is the datapath/IR/memory side.
interface multicycle_control_if #(
  parameter int unsigned OPCODE_WIDTH = 6,
  parameter int unsigned STATE_WIDTH  = 4
);
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    zero;
  logic                    mem_ready;

  logic                    PCWrite;
  logic                    PCWriteCond;
  logic                    IorD;
  logic                    MemRead;
  logic                    MemWrite;
  logic                    MemtoReg;
  logic                    IRWrite;
  logic                    ALUSrcA;
  logic                    RegWrite;
  logic                    RegDst;
  logic [1:0]              PCSource;
  logic [1:0]              ALUOp;
  logic [1:0]              ALUSrcB;
  logic                    pc_enable;
  logic                    illegal_op;
  logic [STATE_WIDTH-1:0]  state_dbg;

  modport master (
    input  opcode, zero, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA,
           RegWrite, RegDst, PCSource, ALUOp, ALUSrcB, pc_enable, illegal_op, state_dbg
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA,
           RegWrite, RegDst, PCSource, ALUOp, ALUSrcB, pc_enable, illegal_op, state_dbg
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM with memory-ready wait states and a sticky
// illegal-opcode flag. Outputs decode from state; FETCH strobes also use mem_ready.
module multicycle_control #(
  parameter int unsigned OPCODE_WIDTH = 6,
  parameter int unsigned STATE_WIDTH  = 4
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus_io
);

  localparam logic [OPCODE_WIDTH-1:0] OpRtype = OPCODE_WIDTH'(6'b000000);
  localparam logic [OPCODE_WIDTH-1:0] OpLw    = OPCODE_WIDTH'(6'b100011);
  localparam logic [OPCODE_WIDTH-1:0] OpSw    = OPCODE_WIDTH'(6'b101011);
  localparam logic [OPCODE_WIDTH-1:0] OpBeq   = OPCODE_WIDTH'(6'b000100);
  localparam logic [OPCODE_WIDTH-1:0] OpJ     = OPCODE_WIDTH'(6'b000010);
  localparam logic [OPCODE_WIDTH-1:0] OpAddi  = OPCODE_WIDTH'(6'b001000);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StRExec    = 4'd6,
    StRWb      = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StAddiExec = 4'd10,
    StAddiWb   = 4'd11
  } state_e;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;

  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg;
  logic       ir_write, alu_src_a, reg_write, reg_dst;
  logic [1:0] pc_source, alu_op, alu_src_b;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    illegal_d     = illegal_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    ir_write      = 1'b0;
    alu_src_a     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    pc_source     = 2'b00;
    alu_op        = 2'b00;
    alu_src_b     = 2'b00;

    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus_io.mem_ready;
        pc_write  = bus_io.mem_ready;
        if (bus_io.mem_ready) state_d = StDecode;
      end
      StDecode: begin
        alu_src_b = 2'b11;
        case (bus_io.opcode)
          OpLw, OpSw: state_d = StMemAddr;
          OpRtype:    state_d = StRExec;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          OpAddi:     state_d = StAddiExec;
          default: begin
            state_d   = StFetch;
            illegal_d = 1'b1;
          end
        endcase
      end
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (bus_io.opcode == OpSw)      state_d = StMemWrite;
        else if (bus_io.opcode == OpLw) state_d = StMemRead;
        else                            state_d = StFetch;
      end
      StMemRead: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (bus_io.mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = StFetch;
      end
      StMemWrite: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (bus_io.mem_ready) state_d = StFetch;
      end
      StRExec: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = StRWb;
      end
      StRWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        state_d       = StFetch;
      end
      StJump: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = StFetch;
      end
      StAddiExec: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = StAddiWb;
      end
      StAddiWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // Write/enable strobes are suppressed while reset is held so an aborted access never commits.
  assign bus_io.PCWrite     = pc_write & reset;
  assign bus_io.PCWriteCond = pc_write_cond & reset;
  assign bus_io.MemRead     = mem_read & reset;
  assign bus_io.MemWrite    = mem_write & reset;
  assign bus_io.IRWrite     = ir_write & reset;
  assign bus_io.RegWrite    = reg_write & reset;
  assign bus_io.pc_enable   = (pc_write | (pc_write_cond & bus_io.zero)) & reset;
  assign bus_io.IorD        = i_or_d;
  assign bus_io.MemtoReg    = mem_to_reg;
  assign bus_io.ALUSrcA     = alu_src_a;
  assign bus_io.RegDst      = reg_dst;
  assign bus_io.PCSource    = pc_source;
  assign bus_io.ALUOp       = alu_op;
  assign bus_io.ALUSrcB     = alu_src_b;
  assign bus_io.illegal_op  = illegal_q;
  assign bus_io.state_dbg   = STATE_WIDTH'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: instruction-level model expands each instruction into per-cycle
// expected states/controls; a monitor compares every cycle against the queue.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_if #(.OPCODE_WIDTH(6), .STATE_WIDTH(4)) bus ();

  multicycle_control #(.OPCODE_WIDTH(6), .STATE_WIDTH(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  typedef struct packed {
    logic       rst_n;
    logic [5:0] op;
    logic       zero;
    logic       mr;
  } stim_t;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic        pce;
    logic        ill;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    applied = 0;
  int    popped = 0;
  bit    done = 0;
  bit    model_ill = 0;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

  function automatic bit is_legal(logic [5:0] op);
    return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_J
        || op == OP_ADDI;
  endfunction

  // Control table per state, in field order
  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,RegWrite,RegDst,
  //  PCSource,ALUOp,ALUSrcB}
  function automatic logic [15:0] ctrl_of(int st, bit mr, bit rst_n);
    bit pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, m2r = 0, irw = 0, asa = 0, rw = 0;
    bit rd = 0;
    logic [1:0] pcs = 0, aop = 0, asb = 0;
    case (st)
      0:  begin mrd = 1; asb = 2'd1; irw = mr; pcw = mr; end
      1:  asb = 2'd3;
      2:  begin asa = 1; asb = 2'd2; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'd2; end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; aop = 2'd1; pcwc = 1; pcs = 2'd1; end
      9:  begin pcw = 1; pcs = 2'd2; end
      10: begin asa = 1; asb = 2'd2; end
      11: rw = 1;
      default: ;
    endcase
    if (!rst_n) begin
      pcw = 0; pcwc = 0; irw = 0; mrd = 0; mwr = 0; rw = 0;
    end
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, pcs, aop, asb};
  endfunction

  // One cycle of the model: push stimulus and the expected observation for that cycle.
  task automatic push_cycle(int st, logic [5:0] op, bit mr, bit rst_n);
    stim_t s;
    exp_t  e;
    logic [15:0] c;
    s.rst_n = rst_n;
    s.op    = op;
    s.zero  = 1'($urandom_range(0, 1));
    s.mr    = mr;
    c       = ctrl_of(st, mr, rst_n);
    e.st    = 4'(st);
    e.ctrl  = c;
    e.pce   = c[15] | (c[14] & s.zero);
    e.ill   = model_ill;
    stim_q.push_back(s);
    exp_q.push_back(e);
    if (!rst_n) model_ill = 0;
    else if (st == 1 && !is_legal(op)) model_ill = 1;
  endtask

  // fw/mw < 0 pick random wait counts; abort_st: -1 none, -2 random cycle, else first
  // cycle spent in that state gets reset asserted.
  task automatic gen_instr(logic [5:0] op, int fw, int mw, int abort_st);
    int sts[$];
    bit mrs[$];
    int nf = (fw < 0) ? int'($urandom_range(0, 2)) : fw;
    int nm = (mw < 0) ? int'($urandom_range(0, 3)) : mw;
    int cut;
    repeat (nf) begin sts.push_back(0); mrs.push_back(0); end
    sts.push_back(0); mrs.push_back(1);
    sts.push_back(1); mrs.push_back(1'($urandom_range(0, 1)));
    case (op)
      OP_LW: begin
        sts.push_back(2); mrs.push_back(1'($urandom_range(0, 1)));
        repeat (nm) begin sts.push_back(3); mrs.push_back(0); end
        sts.push_back(3); mrs.push_back(1);
        sts.push_back(4); mrs.push_back(1'($urandom_range(0, 1)));
      end
      OP_SW: begin
        sts.push_back(2); mrs.push_back(1'($urandom_range(0, 1)));
        repeat (nm) begin sts.push_back(5); mrs.push_back(0); end
        sts.push_back(5); mrs.push_back(1);
      end
      OP_R:    begin sts.push_back(6); sts.push_back(7); mrs.push_back(1); mrs.push_back(0); end
      OP_ADDI: begin sts.push_back(10); sts.push_back(11); mrs.push_back(0); mrs.push_back(1); end
      OP_BEQ:  begin sts.push_back(8); mrs.push_back(1'($urandom_range(0, 1))); end
      OP_J:    begin sts.push_back(9); mrs.push_back(1'($urandom_range(0, 1))); end
      default: ;
    endcase
    cut = -1;
    if (abort_st == -2) cut = int'($urandom_range(0, sts.size() - 1));
    else if (abort_st >= 0) begin
      for (int i = 0; i < sts.size(); i++) if (cut < 0 && sts[i] == abort_st) cut = i;
    end
    for (int i = 0; i < sts.size(); i++) begin
      if (cut >= 0 && i > cut) break;
      push_cycle(sts[i], op, mrs[i], !(i == cut));
    end
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] op;
    case ($urandom_range(0, 6))
      0: op = OP_R;
      1: op = OP_LW;
      2: op = OP_SW;
      3: op = OP_BEQ;
      4: op = OP_J;
      5: op = OP_ADDI;
      default: begin
        op = 6'($urandom_range(0, 63));
        while (is_legal(op)) op = 6'($urandom_range(0, 63));
      end
    endcase
    return op;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, popped, got, exp);
    end
  endtask

  // Monitor: one expected entry per applied cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (popped < applied) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow cycle=%0d got=empty expected=entry", popped);
      end else begin
        e = exp_q.pop_front();
        check("state_dbg", 32'(bus.state_dbg), 32'(e.st));
        check("controls", 32'({bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                               bus.MemWrite, bus.MemtoReg, bus.IRWrite, bus.ALUSrcA,
                               bus.RegWrite, bus.RegDst, bus.PCSource, bus.ALUOp,
                               bus.ALUSrcB}), 32'(e.ctrl));
        check("pc_enable", 32'(bus.pc_enable), 32'(e.pce));
        check("illegal_op", 32'(bus.illegal_op), 32'(e.ill));
      end
      popped++;
    end
  end

  initial begin
    int cyc;
    reset         = 1'b0;
    bus.opcode    = '0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;

    // Reset-state observation, then directed scenarios, then random traffic.
    push_cycle(0, OP_R, 1, 0);
    gen_instr(OP_LW, 0, 0, -1);
    gen_instr(OP_SW, 0, 3, -1);
    gen_instr(OP_BEQ, 0, 0, -1);
    gen_instr(OP_BEQ, 2, 0, -1);
    gen_instr(6'b111111, 0, 0, -1);
    gen_instr(OP_R, 0, 0, -1);
    gen_instr(OP_ADDI, 1, 0, -1);
    gen_instr(OP_LW, 0, 2, 3);
    gen_instr(OP_J, 0, 0, -1);
    gen_instr(6'b111111, 0, 0, -1);
    gen_instr(OP_SW, 0, 3, 5);
    for (int n = 0; n < 150; n++) gen_instr(rand_op(), -1, -1, ($urandom_range(0, 9) == 0) ? -2 : -1);

    fork
      begin
        stim_t s;
        repeat (3) @(posedge clk);
        while (stim_q.size() > 0) begin
          s = stim_q.pop_front();
          #1;
          reset         = s.rst_n;
          bus.opcode    = s.op;
          bus.zero      = s.zero;
          bus.mem_ready = s.mr;
          applied++;
          @(posedge clk);
        end
        done = 1;
      end
    join_none

    cyc = 0;
    while (!done && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    checks++;
    if (!done || exp_q.size() != 0 || popped != applied) begin
      errors++;
      $display("FAIL completion got=done:%0d left:%0d expected=done:1 left:0", done,
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have parameter OPCODE_WIDTH, default 6, the width of the instruction opcode field.
REQ-002 The block SHALL have parameter STATE_WIDTH, default 4, the width of the state register and debug port.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 opcode  input  OPCODE_WIDTH  opcode from instruction register, bits [31:26].
REQ-006 zero  input  1  ALU zero flag, for beq.
REQ-007 mem_ready  input  1  memory handshake; 1 = current read/write completes this cycle.
REQ-008 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  datapath controls.
REQ-009 PCSource, ALUOp, ALUSrcB  output  2 each  datapath mux selects / ALU class.
REQ-010 pc_enable  output  1  PCWrite | (PCWriteCond & zero), drives PC register enable.
REQ-011 illegal_op  output  1  sticky flag, unsupported opcode decoded.
REQ-012 state_dbg  output  STATE_WIDTH  current state encoding.

Function
REQ-013 States SHALL be FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11; codes 12-15 unreachable and SHALL go to FETCH.
REQ-014 Opcodes SHALL be R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
REQ-015 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=mem_ready; stays in FETCH while mem_ready=0, else DECODE.
REQ-016 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next by opcode: lw/sw->MEM_ADDR, R->R_EXEC, beq->BRANCH, j->JUMP, addi->ADDI_EXEC, other->FETCH with illegal_op set.
REQ-017 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; lw->MEM_READ, sw->MEM_WRITE.
REQ-018 MEM_READ: MemRead=1, IorD=1; wait while mem_ready=0, then MEM_WB.
REQ-019 MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0; ->FETCH.
REQ-020 MEM_WRITE: MemWrite=1, IorD=1, held while mem_ready=0; ->FETCH on mem_ready=1.
REQ-021 R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; ->R_WB. R_WB: RegWrite=1, RegDst=1, MemtoReg=0; ->FETCH.
REQ-022 ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00; ->ADDI_WB. ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0; ->FETCH.
REQ-023 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; ->FETCH.
REQ-024 JUMP: PCWrite=1, PCSource=10; ->FETCH.
REQ-025 Every control not listed for a state SHALL be 0; outputs SHALL depend only on state, except FETCH strobes qualified by mem_ready.
REQ-026 Cycle counts with mem_ready=1: lw 5, sw 4, R/addi 4, beq 3, j 3.
REQ-027 illegal_op SHALL stay 1 until reset; the FSM keeps executing subsequent instructions.

Reset
REQ-028 On a rising edge with reset=0 the state SHALL become FETCH and illegal_op 0, regardless of current state or mem_ready.
REQ-029 While reset=0 PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite and pc_enable SHALL be forced to 0.
REQ-030 Reset asserted mid-wait (MEM_READ/MEM_WRITE) SHALL abandon the access with no write strobe issued.

Verification
REQ-031 Release reset, mem_ready=1, opcode=100011 -> state_dbg 0,1,2,3,4,0; RegWrite=1, MemtoReg=1 only in state 4.
REQ-032 opcode=101011, mem_ready low for 3 cycles in MEM_WRITE -> MemWrite=1 for 4 cycles, then FETCH.
REQ-033 opcode=000100, zero=1 then zero=0 -> pc_enable=1 in BRANCH first run, 0 second; PCSource=01 both.
REQ-034 opcode=111111 -> DECODE->FETCH, illegal_op=1 persists through next valid instruction until reset=0.
REQ-035 mem_ready=0 in FETCH for 2 cycles -> IRWrite=PCWrite=0 those cycles, 1 on third, then DECODE.
REQ-036 reset=0 pulsed in MEM_READ -> next state_dbg=0, all strobes 0 during reset, illegal_op=0.
